// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths, pipeline latency constants and hazard flag bundle for the
// register scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned SB_ADDR_W = 5;
    localparam int unsigned SB_LAT_W  = 3;
    localparam int unsigned SB_CNT_W  = 32;

    // Result (R) and writeback (W) ages for the standard functional units
    localparam int unsigned LAT_ALU_R  = 1;
    localparam int unsigned LAT_LD_R   = 2;
    localparam int unsigned LAT_PIPE_W = 3;
    localparam int unsigned LAT_MUL_R  = 5;
    localparam int unsigned LAT_MUL_W  = 6;

    typedef struct packed {
        logic rawA;
        logic rawB;
        logic port;
        logic waw;
    } hazardVec_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request bundle into the scoreboard and its stall/forward responses.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned LAT_W  = SB_LAT_W,
    parameter int unsigned CNT_W  = SB_CNT_W
);
    logic                 id_valid;
    logic [ADDR_W-1:0]    id_rs;
    logic [ADDR_W-1:0]    id_rt;
    logic                 id_use_rs;
    logic                 id_use_rt;
    logic                 id_we;
    logic [ADDR_W-1:0]    id_dst;
    logic [LAT_W-1:0]     id_rlat;
    logic [LAT_W-1:0]     id_wlat;
    logic                 flush;
    logic                 ext_stall;
    logic                 stall;
    logic                 issue;
    logic [LAT_W-1:0]     fwd_sel_a;
    logic [LAT_W-1:0]     fwd_sel_b;
    logic [2**ADDR_W-1:0] busy;
    logic [CNT_W-1:0]     stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_we, id_dst,
               id_rlat, id_wlat, flush, ext_stall,
        input  stall, issue, fwd_sel_a, fwd_sel_b, busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_we, id_dst,
               id_rlat, id_wlat, flush, ext_stall,
        output stall, issue, fwd_sel_a, fwd_sel_b, busy, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard entry: tracks an in-flight write's age and its result and
// writeback latencies; clears itself once the register file has been written.
module sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned LAT_W = SB_LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [LAT_W-1:0] loadRlat,
    input  logic [LAT_W-1:0] loadWlat,
    output logic             valid,
    output logic [LAT_W-1:0] age,
    output logic [LAT_W-1:0] rlat,
    output logic [LAT_W-1:0] rem
);
    logic [LAT_W-1:0] wlat;

    // A new issue overrides any retire on the same edge; otherwise age or retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            age   <= '0;
            rlat  <= '0;
            wlat  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            age   <= LAT_W'(1);
            rlat  <= loadRlat;
            wlat  <= loadWlat;
        end else if (valid && advance) begin
            if (age == wlat) begin
                valid <= 1'b0;
            end else begin
                age <= age + LAT_W'(1);
            end
        end
    end

    assign rem = wlat - age;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard at ID: detects RAW, WAW-ordering and write-port
// hazards against all in-flight writes and selects operand forwarding ages.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned LAT_W  = SB_LAT_W,
    parameter int unsigned CNT_W  = SB_CNT_W
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] entValid;
    logic [NREGS-1:0] portMatch;
    logic [LAT_W-1:0] entAge  [NREGS];
    logic [LAT_W-1:0] entRlat [NREGS];
    logic [LAT_W-1:0] entRem  [NREGS];
    logic             writeIssue;
    logic             stall;
    logic             issue;
    logic [CNT_W-1:0] stallCnt;
    hazardVec_t       haz;

    // r0 is never tracked
    assign entValid[0]  = 1'b0;
    assign portMatch[0] = 1'b0;
    assign entAge[0]    = '0;
    assign entRlat[0]   = '0;
    assign entRem[0]    = '0;

    assign writeIssue = issue && sb.id_we && (sb.id_dst != '0);

    for (genvar i = 1; i < NREGS; i++) begin : gEntry
        sb_entry #(.LAT_W(LAT_W)) uEntry (
            .clk      (clk),
            .rst      (rst),
            .load     (writeIssue && (sb.id_dst == ADDR_W'(i))),
            .advance  (!sb.ext_stall),
            .loadRlat (sb.id_rlat),
            .loadWlat (sb.id_wlat),
            .valid    (entValid[i]),
            .age      (entAge[i]),
            .rlat     (entRlat[i]),
            .rem      (entRem[i])
        );
        assign portMatch[i] = entValid[i] && (entRem[i] == sb.id_wlat);
    end

    // Hazard flags from scoreboard state and the instruction in ID
    always_comb begin
        haz      = '0;
        haz.rawA = sb.id_use_rs && entValid[sb.id_rs] &&
                   (entAge[sb.id_rs] < entRlat[sb.id_rs]);
        haz.rawB = sb.id_use_rt && entValid[sb.id_rt] &&
                   (entAge[sb.id_rt] < entRlat[sb.id_rt]);
        haz.port = sb.id_we && (sb.id_dst != '0) && (|portMatch);
        haz.waw  = sb.id_we && entValid[sb.id_dst] &&
                   (entRem[sb.id_dst] > sb.id_wlat);
    end

    assign stall = sb.id_valid && !sb.flush && (|haz);
    assign issue = sb.id_valid && !stall && !sb.flush && !sb.ext_stall;

    assign sb.stall     = stall;
    assign sb.issue     = issue;
    assign sb.busy      = entValid;
    assign sb.stall_cnt = stallCnt;
    assign sb.fwd_sel_a = (sb.id_use_rs && entValid[sb.id_rs]) ?
                          entAge[sb.id_rs] + LAT_W'(1) : '0;
    assign sb.fwd_sel_b = (sb.id_use_rt && entValid[sb.id_rt]) ?
                          entAge[sb.id_rt] + LAT_W'(1) : '0;

    // Saturating count of hazard-stall cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (stall && !(&stallCnt)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

endmodule
